// File: rtl/ysyx_23060077_axil_sram_slave.sv
// AXI4-Lite word-addressed SRAM responder with programmable read/write
// response latency. Out-of-range accesses complete with SLVERR.
module ysyx_23060077_axil_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
    localparam logic [3:0]  R_LAT  = READ_LAT[3:0];
    localparam logic [3:0]  W_LAT  = WRITE_LAT[3:0];
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    // 33-bit compare so addresses below BASE_ADDR wrap to a huge offset
    function automatic logic in_range(input logic [31:0] a);
        return (({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [3:0]  r_cnt;
    logic [31:0] ar_addr_q;

    // read FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid)      r_next = R_WAIT;
            R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
            R_RESP:  if (rready)       r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // read handshake outputs decoded from state
    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid  = (r_state == R_RESP);
    end

    // read datapath: latch address, count down, sample memory on exit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= 4'd0;
            ar_addr_q <= 32'h0;
            rdata     <= 32'h0;
            rresp     <= OKAY;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                ar_addr_q <= araddr;
                r_cnt     <= R_LAT;
            end else if (r_state == R_WAIT) begin
                if (r_cnt == 4'd0) begin
                    if (in_range(ar_addr_q)) begin
                        rdata <= mem[word_idx(ar_addr_q)];
                        rresp <= OKAY;
                    end else begin
                        rdata <= 32'h0;
                        rresp <= SLVERR;
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [3:0]  w_cnt;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_fire, w_fire, both_got, w_exit, w_commit;

    always_comb begin
        aw_fire  = awvalid && awready;
        w_fire   = wvalid && wready;
        both_got = (aw_got || aw_fire) && (w_got || w_fire);
        w_exit   = (w_state == W_WAIT) && (w_cnt == 4'd0);
        w_commit = w_exit && in_range(aw_addr_q);
    end

    // write FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // write FSM next state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (both_got) w_next = W_WAIT;
            W_WAIT:  if (w_exit)   w_next = W_RESP;
            W_RESP:  if (bready)   w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // write handshake outputs: each ready drops once its beat is held
    always_comb begin
        awready = (w_state == W_IDLE) && !aw_got;
        wready  = (w_state == W_IDLE) && !w_got;
        bvalid  = (w_state == W_RESP);
    end

    // write datapath: capture AW/W independently, count down, set bresp
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            w_cnt     <= 4'd0;
            bresp     <= OKAY;
        end else begin
            if (aw_fire) begin
                aw_addr_q <= awaddr;
                aw_got    <= 1'b1;
            end
            if (w_fire) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                w_got   <= 1'b1;
            end
            if (w_state == W_IDLE && both_got) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                w_cnt  <= W_LAT;
            end else if (w_state == W_WAIT) begin
                if (w_cnt == 4'd0) bresp <= in_range(aw_addr_q) ? OKAY : SLVERR;
                else               w_cnt <= w_cnt - 4'd1;
            end
        end
    end

    // memory byte-lane commit; a concurrent read sample sees the old word
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[word_idx(aw_addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_axil_sram_slave.sv
// Randomized self-checking bench for the AXI4-Lite SRAM responder.
module tb_ysyx_23060077_axil_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          RLAT  = 2;
    localparam int          WLAT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    ysyx_23060077_axil_sram_slave #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LAT(RLAT), .WRITE_LAT(WLAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint unsigned la = a;
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // AW and W presented together; lat counts cycles from capture to bvalid
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        int t;
        bit fa, fw;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; t = 0;
        while ((awvalid || wvalid) && t < 50) begin
            fa = awvalid && awready;
            fw = wvalid && wready;
            @(negedge clk); t++;
            if (fa) awvalid = 1'b0;
            if (fw) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
        resp = bresp;
        bready = 1'b1; @(negedge clk); bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] resp, output int lat);
        int t;
        araddr = a; arvalid = 1'b1; t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk); arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
        d = rdata; resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", 32'(rvalid), 32'd1);
            chk("r_hold_data", rdata, d);
        end
        rready = 1'b1; @(negedge clk); rready = 1'b0;
    endtask

    task automatic write_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        logic [1:0] resp;
        int lat;
        bit ok;
        ok = addr_ok(a);
        axi_write(a, d, s, resp, lat);
        chk({tag, "_bresp"}, 32'(resp), ok ? 32'd0 : 32'd2);
        chk({tag, "_blat"}, 32'(lat), 32'(WLAT + 1));
        if (ok) model[int'(a - BASE) >> 2] =
            merge(model.exists(int'(a - BASE) >> 2) ? model[int'(a - BASE) >> 2] : 32'h0, d, s);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input int hold);
        logic [31:0] d;
        logic [1:0]  resp;
        int lat;
        bit ok;
        ok = addr_ok(a);
        axi_read(a, hold, d, resp, lat);
        chk({tag, "_rresp"}, 32'(resp), ok ? 32'd0 : 32'd2);
        chk({tag, "_rlat"}, 32'(lat), 32'(RLAT + 1));
        chk({tag, "_rdata"}, d, ok ? model[int'(a - BASE) >> 2] : 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, last;
        logic [1:0]  resp;
        int lat, seen;
        rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;

        // T1 reset
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        chk("t1_arready", 32'(arready), 32'd1);
        chk("t1_awready", 32'(awready), 32'd1);
        chk("t1_wready", 32'(wready), 32'd1);
        chk("t1_rvalid", 32'(rvalid), 32'd0);
        chk("t1_bvalid", 32'(bvalid), 32'd0);
        chk("t1_rdata", rdata, 32'h0);

        // T2 write then read
        write_chk("t2w", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        read_chk("t2r", 32'h8000_0010, 0);

        // T3 partial strobe
        write_chk("t3a", 32'h8000_0020, 32'h1122_3344, 4'hF);
        write_chk("t3b", 32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
        axi_read(32'h8000_0020, 0, d, resp, lat);
        chk("t3_rdata", d, 32'h11BB_33DD);

        // T4 W leads AW by several cycles
        @(negedge clk);
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        repeat (4) begin @(negedge clk); chk("t4_wready_low", 32'(wready), 32'd0); end
        wvalid = 1'b0; awaddr = 32'h8000_0030; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 50) begin
            chk("t4_wready_wait", 32'(wready), 32'd0);
            @(negedge clk); lat++;
        end
        chk("t4_blat", 32'(lat), 32'(WLAT + 1));
        chk("t4_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; @(negedge clk); bready = 1'b0;
        model[12] = 32'hCAFE_F00D;
        chk("t4_wready_back", 32'(wready), 32'd1);
        seen = 0;
        repeat (4) begin @(negedge clk); if (bvalid) seen++; end
        chk("t4_single_b", 32'(seen), 32'd0);
        read_chk("t4r", 32'h8000_0030, 0);

        // T5 out of range
        read_chk("t5r", 32'h7FFF_FFFC, 0);
        a = BASE + 32'(4 * DEPTH) - 32'd4;
        write_chk("t5_last", a, 32'h0BAD_F00D, 4'hF);
        write_chk("t5w", BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
        read_chk("t5_last_r", a, 0);
        read_chk("t5_first_r", 32'h8000_0010, 0);

        // T6 backpressure then reset during W_WAIT
        read_chk("t6_bp", 32'h8000_0010, 10);
        write_chk("t6_pre", 32'h8000_0040, 32'h5555_AAAA, 4'hF);
        awaddr = 32'h8000_0040; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("t6_rst_bvalid", 32'(bvalid), 32'd0);
        chk("t6_rst_awready", 32'(awready), 32'd1);
        chk("t6_rst_wready", 32'(wready), 32'd1);
        seen = 0;
        repeat (5) begin @(negedge clk); if (bvalid) seen++; end
        chk("t6_no_b", 32'(seen), 32'd0);
        read_chk("t6_r", 32'h8000_0040, 0);

        // randomized traffic over a small initialised window plus stray addresses
        for (int i = 0; i < 16; i++) write_chk("init", BASE + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 4));
                1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 1) write_chk("rnd_w", a, $urandom, 4'($urandom));
            else                           read_chk("rnd_r", a, $urandom_range(0, 3));
        end

        last = 32'(n_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, last);
        $finish;
    end
endmodule
